// File: rtl/wb_stage_pkg.sv
// Shared NPC pipeline definitions: datapath width, load funct3 codes and
// the writeback-stage state encoding.
package npc_defs;

    localparam int XLEN = 64;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    typedef enum logic [1:0] {
        WB_IDLE      = 2'd0,
        WB_LOAD_WAIT = 2'd1,
        WB_READY     = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load data aligner: shifts the returned doubleword down by the
// byte offset (zero fill), then sign/zero-extends to the width given by funct3.
module load_align
    import npc_defs::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      op,
    input  logic [2:0]      addr_lo,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0]   s;
    logic signed [7:0]  s_b;
    logic signed [15:0] s_h;
    logic signed [31:0] s_w;

    assign s   = rdata >> {addr_lo, 3'b000};
    assign s_b = s[7:0];
    assign s_h = s[15:0];
    assign s_w = s[31:0];

    always_comb begin
        data = '0;
        case (op)
            LB:      data = XLEN'(s_b);
            LH:      data = XLEN'(s_h);
            LW:      data = XLEN'(s_w);
            LD:      data = s;
            LBU:     data = {56'd0, s[7:0]};
            LHU:     data = {48'd0, s[15:0]};
            LWU:     data = {32'd0, s[31:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: holds one instruction, waits for load data, drives the
// regfile write port and forwarding info. WB_COMMIT_TRACE_EN adds commit trace ports.
module wb_stage
    import npc_defs::*;
#(
    parameter int NREG_BITS = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ms_to_ws_valid,
    output logic                 ws_allowin,
    input  logic [XLEN-1:0]      ms_pc,
    input  logic [NREG_BITS-1:0] ms_rd,
    input  logic                 ms_rd_we,
    input  logic                 ms_is_load,
    input  logic [2:0]           ms_load_op,
    input  logic [2:0]           ms_addr_lo,
    input  logic [XLEN-1:0]      ms_result,
    input  logic                 dmem_rvalid,
    input  logic [XLEN-1:0]      dmem_rdata,
    output logic                 rf_we,
    output logic [NREG_BITS-1:0] rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic                 ws_fwd_valid,
    output logic                 ws_fwd_busy,
    output logic [NREG_BITS-1:0] ws_fwd_rd,
    output logic [XLEN-1:0]      ws_fwd_data
`ifdef WB_COMMIT_TRACE_EN
    ,
    output logic                 commit_valid,
    output logic [XLEN-1:0]      commit_pc
`endif
);

    wb_state_e state, state_nxt;

    logic [XLEN-1:0]      pc_p0;
    logic [NREG_BITS-1:0] rd_p0;
    logic                 rd_we_p0;
    logic [2:0]           op_p0;
    logic [2:0]           addr_lo_p0;
    logic [XLEN-1:0]      result_p0;
    logic [XLEN-1:0]      load_data;
    logic                 accept;
    logic                 writes_rd;

    load_align u_load_align (
        .rdata   (dmem_rdata),
        .op      (op_p0),
        .addr_lo (addr_lo_p0),
        .data    (load_data)
    );

    assign ws_allowin = (state == WB_IDLE) || (state == WB_READY);
    assign accept     = ms_to_ws_valid && ws_allowin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WB_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WB_IDLE, WB_READY: begin
                if (accept) state_nxt = ms_is_load ? WB_LOAD_WAIT : WB_READY;
                else        state_nxt = WB_IDLE;
            end
            WB_LOAD_WAIT: if (dmem_rvalid) state_nxt = WB_READY;
            default:      state_nxt = WB_IDLE;
        endcase
    end

    // Stage p0: instruction held in writeback; a load overwrites result on response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_p0      <= '0;
            rd_p0      <= '0;
            rd_we_p0   <= 1'b0;
            op_p0      <= '0;
            addr_lo_p0 <= '0;
            result_p0  <= '0;
        end else if (accept) begin
            pc_p0      <= ms_pc;
            rd_p0      <= ms_rd;
            rd_we_p0   <= ms_rd_we;
            op_p0      <= ms_load_op;
            addr_lo_p0 <= ms_addr_lo;
            result_p0  <= ms_result;
        end else if (state == WB_LOAD_WAIT && dmem_rvalid) begin
            result_p0  <= load_data;
        end
    end

    // x0 is hard-wired zero: never written, never forwarded
    assign writes_rd = rd_we_p0 && (rd_p0 != '0);

    assign rf_we        = (state == WB_READY) && writes_rd;
    assign rf_waddr     = rd_p0;
    assign rf_wdata     = result_p0;
    assign ws_fwd_valid = (state != WB_IDLE) && writes_rd;
    assign ws_fwd_busy  = (state == WB_LOAD_WAIT);
    assign ws_fwd_rd    = rd_p0;
    assign ws_fwd_data  = result_p0;

`ifdef WB_COMMIT_TRACE_EN
    assign commit_valid = (state == WB_READY);
    assign commit_pc    = pc_p0;
`else
    logic unused_pc;
    assign unused_pc = ^pc_p0;
`endif

endmodule
